parity_accum: RTL
=================

PARITY_ACCUM -- requirements
Module: parity_accum

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 2..64.
REQ-002 Parameter FRAME_LEN, default 4: maximum beats per frame, legal range 1..255.
REQ-003 clk  input  1: sole clock; all state updates on rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 mode  input  1: 0 = XOR (even) parity, 1 = XNOR (odd) parity; sampled on first beat of each frame.
REQ-006 in_valid  input  1: input beat valid.
REQ-007 in_ready  output  1: block accepts an input beat.
REQ-008 in_data  input  WIDTH: input data word.
REQ-009 in_last  input  1: marks the final beat of a frame.
REQ-010 out_valid  output  1: result is valid.
REQ-011 out_ready  input  1: consumer accepts the result.
REQ-012 out_col  output  WIDTH: bitwise column parity of the frame.
REQ-013 out_row  output  1: reduction parity of out_col.
REQ-014 out_count  output  $clog2(FRAME_LEN+1): number of beats in the frame.

Function
REQ-015 A beat or result transfers only on a rising edge where valid and ready are both 1.
REQ-016 The FSM has three states: IDLE, ACCUM and HOLD.
REQ-017 In IDLE, in_ready=1 and out_valid=0; the first accepted beat sets acc=in_data, count=1 and latches mode.
REQ-018 On the first beat, the FSM goes to HOLD if in_last=1 or FRAME_LEN=1; otherwise it goes to ACCUM.
REQ-019 In ACCUM, in_ready=1; each accepted beat updates acc ^= in_data and count += 1.
REQ-020 ACCUM goes to HOLD on an accepted beat with in_last=1 or with the updated count equal to FRAME_LEN.
REQ-021 In HOLD, in_ready=0 and out_valid=1, with the following outputs:
  - out_col = acc, or ~acc when the latched mode is 1;
  - out_row = XOR-reduction of acc, inverted when the latched mode is 1;
  - out_count = count.
REQ-022 HOLD returns to IDLE on a result handshake; acc and count clear to 0 on the same edge.
REQ-023 Latency: out_valid rises on the first edge after the final beat is accepted.
REQ-024 Outputs SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-025 Changes to mode after the first beat SHALL NOT affect the current frame.
REQ-026 in_last on a beat that also reaches FRAME_LEN SHALL close exactly one frame.
REQ-027 in_data and in_last SHALL be ignored whenever in_ready=0.
REQ-028 out_col, out_row and out_count SHALL read 0 whenever out_valid=0.

Reset
REQ-029 While reset=1, the block SHALL hold: state=IDLE, acc=0, count=0, latched mode=0, in_ready=0, out_valid=0, all data outputs 0.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the frame immediately; no partial result is emitted.
REQ-031 in_ready SHALL rise on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro PARITY_CHECK_EN, when defined, adds two ports:
  - exp_row  input  1: expected row parity, sampled with the final accepted beat;
  - err  output  1: equals (out_row != latched exp_row) while out_valid=1, else 0; reset value 0.
REQ-033 When PARITY_CHECK_EN is undefined, exp_row, err and the associated register SHALL NOT exist, and all other behaviour SHALL be unchanged.

Structure
REQ-034 A shared package parity_pkg SHALL hold the FSM state typedef (IDLE/ACCUM/HOLD) and the mode encodings PAR_XOR=0 and PAR_XNOR=1.
REQ-035 The column XOR SHALL be built from WIDTH instances of sub-module nand_xor2: a 2-input XOR made of four 2-input NANDs, with no other gates.
REQ-036 The reduction for out_row SHALL be a tree of nand_xor2 instances.

Verification (WIDTH=8, FRAME_LEN=4)
REQ-037 mode=0, beats 0x0F,0xF0,0xFF,0x01 with no in_last -> one cycle after beat 4: out_col=0x01, out_row=1, out_count=4.
REQ-038 mode=1 with the same beats -> out_col=0xFE, out_row=0, out_count=4; mode toggled after beat 1 -> identical result.
REQ-039 Beats 0xAA, then 0x55 with in_last=1 -> out_col=0xFF, out_row=0, out_count=2, in_ready=0 during HOLD.
REQ-040 out_ready=0 for 5 cycles in HOLD -> out_valid and all outputs stable, in_valid beats ignored; out_ready=1 -> IDLE next edge.
REQ-041 reset pulsed after 2 beats of a frame -> all outputs 0, no result emitted; next frame 0x3C alone with in_last -> out_col=0x3C, out_row=0, out_count=1.
REQ-042 With PARITY_CHECK_EN defined, exp_row=0 on the scenario REQ-037 frame -> err=1; exp_row=1 -> err=0.

Source files
------------

// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity accumulator:
//   - state_t  : accumulator FSM states (IDLE / ACCUM / HOLD)
//   - PAR_XOR  : even parity mode encoding (result reported as-is)
//   - PAR_XNOR : odd parity mode encoding (result reported inverted)
//   - apply_mode() : applies the latched parity mode to one parity bit
// ---------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic PAR_XOR  = 1'b0;
    localparam logic PAR_XNOR = 1'b1;

    // Odd-parity (XNOR) mode reports the complement of the raw XOR result.
    function automatic logic apply_mode(input logic bit_in, input logic mode_in);
        return bit_in ^ (mode_in == PAR_XNOR);
    endfunction

endpackage : parity_pkg

// File: rtl/nand_xor2.sv
// ---------------------------------------------------------------------------
// nand_xor2
// Two-input XOR built purely from four two-input NAND gates.
// Ports:
//   a, b : operand bits
//   y    : a ^ b
// ---------------------------------------------------------------------------
module nand_xor2 (
    input  logic a,
    input  logic b,
    output logic y
);

    logic n_ab;
    logic n_a;
    logic n_b;

    // Classic 4-NAND XOR: the shared first NAND feeds both side NANDs.
    assign n_ab = ~(a & b);
    assign n_a  = ~(a & n_ab);
    assign n_b  = ~(b & n_ab);
    assign y    = ~(n_a & n_b);

endmodule : nand_xor2

// File: rtl/parity_accum.sv
// ---------------------------------------------------------------------------
// parity_accum
// Accumulates a bitwise column parity over a frame of up to FRAME_LEN data
// beats, then presents the column parity, its row (reduction) parity and the
// beat count until the consumer takes it.
//
// Parameters:
//   WIDTH     : data word width (2..64)
//   FRAME_LEN : maximum beats per frame (1..255)
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   mode       : 0 = even (XOR) parity, 1 = odd (XNOR); sampled on first beat
//   in_valid / in_ready / in_data / in_last : input beat handshake
//   out_valid / out_ready                   : result handshake
//   out_col    : column parity of the frame (0 while out_valid=0)
//   out_row    : reduction parity of the frame (0 while out_valid=0)
//   out_count  : beats in the frame (0 while out_valid=0)
//
// Optional feature (macro PARITY_CHECK_EN):
//   exp_row    : expected row parity, captured with the final accepted beat
//   err        : out_row != captured exp_row while out_valid=1, else 0
// ---------------------------------------------------------------------------
module parity_accum
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_col,
    output logic                           out_row,
    output logic [$clog2(FRAME_LEN+1)-1:0] out_count
`ifdef PARITY_CHECK_EN
    ,
    input  logic                           exp_row,
    output logic                           err
`endif
);

    localparam int CW     = $clog2(FRAME_LEN + 1);
    localparam int LVLS   = $clog2(WIDTH);
    localparam int LEAVES = 1 << LVLS;
    localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mode_q, mode_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             in_fire;
    logic             out_fire;
    logic [CW-1:0]    count_inc;
    logic [WIDTH-1:0] col_xor;
    logic [LEAVES-1:0] leaf;
    logic             acc_parity;

`ifdef PARITY_CHECK_EN
    logic             exp_row_q, exp_row_d;
`endif

    // -----------------------------------------------------------------------
    // Column XOR: one NAND-built XOR per data bit, acc ^ in_data.
    // -----------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_col
            nand_xor2 u_xor (
                .a (acc_q[gi]),
                .b (in_data[gi]),
                .y (col_xor[gi])
            );
        end

        // Reduction tree leaves, padded with zeros up to a power of two so
        // every level halves cleanly; zero leaves do not change the parity.
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < WIDTH) begin : g_data
                assign leaf[gi] = acc_q[gi];
            end else begin : g_pad
                assign leaf[gi] = 1'b0;
            end
        end

        // One generate block per tree level; each level reads the previous
        // level's outputs, which keeps every net single-level and acyclic.
        for (gi = 0; gi < LVLS; gi++) begin : g_lvl
            localparam int N = LEAVES >> (gi + 1);
            logic [2*N-1:0] src;
            logic [N-1:0]   y;

            if (gi == 0) begin : g_first
                assign src = leaf;
            end else begin : g_next
                assign src = g_lvl[gi-1].y;
            end

            for (gj = 0; gj < N; gj++) begin : g_node
                nand_xor2 u_xor (
                    .a (src[2*gj]),
                    .b (src[2*gj+1]),
                    .y (y[gj])
                );
            end
        end
    endgenerate

    assign acc_parity = g_lvl[LVLS-1].y[0];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        in_fire   = in_valid & in_ready_q;
        out_fire  = out_valid_q & out_ready;
        count_inc = count_q + CW'(1);

        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        mode_d  = mode_q;
`ifdef PARITY_CHECK_EN
        exp_row_d = exp_row_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    acc_d   = in_data;
                    count_d = CW'(1);
                    mode_d  = mode;
                    if (in_last || (FRAME_LEN == 1)) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
`ifdef PARITY_CHECK_EN
                    exp_row_d = exp_row;
`endif
                end
            end

            ACCUM: begin
                if (in_fire) begin
                    acc_d   = col_xor;
                    count_d = count_inc;
                    // in_last together with a full count still closes only
                    // this one frame: both conditions lead to the same HOLD.
                    if (in_last || (count_inc == FRAME_LEN_C)) begin
                        state_d = HOLD;
                    end
`ifdef PARITY_CHECK_EN
                    exp_row_d = exp_row;
`endif
                end
            end

            HOLD: begin
                if (out_fire) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                acc_d   = '0;
                count_d = '0;
            end
        endcase

        // Handshake flags are registered images of the next state, so they
        // switch on the same edge as the state and stay low during reset.
        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            mode_q      <= PAR_XOR;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            exp_row_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef PARITY_CHECK_EN
            exp_row_q   <= exp_row_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: data outputs are forced to zero outside HOLD.
    // -----------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_col   = out_valid_q ? (acc_q ^ {WIDTH{mode_q}}) : '0;
    assign out_row   = out_valid_q & apply_mode(acc_parity, mode_q);
    assign out_count = out_valid_q ? count_q : '0;

`ifdef PARITY_CHECK_EN
    assign err = out_valid_q & (out_row != exp_row_q);
`endif

endmodule : parity_accum
